// File: rtl/arbiter_match_ctrl.sv
// Match-level scheduler for the reaction game: countdown -> race -> winner display, with scoring.
// Optional false-start handling during the countdown is enabled by defining ARBITER_MATCH_FOUL_EN.
module arbiter_match_ctrl #(
    parameter int unsigned ROUNDS_TO_WIN  = 3,
    parameter int unsigned SCORE_W        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_in,
    input  logic               req1,
    input  logic               req2,
    input  logic               cd_done_in,
    input  logic               w_done_in,
    output logic               cd_rst_out,
    output logic               w_rst_out,
    output logic               gnt1_out,
    output logic               gnt2_out,
    output logic [SCORE_W-1:0] score1_out,
    output logic [SCORE_W-1:0] score2_out,
    output logic               match_over_out,
    output logic [1:0]         match_winner_out
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(ROUNDS_TO_WIN);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        ARMED     = 3'd2,
        SHOW      = 3'd3,
        SCORE     = 3'd4,
        RELEASE   = 3'd5,
        MATCH_END = 3'd6
    } state_t;

    state_t            state;
    logic              tie_p2;
    logic [TO_W-1:0]   to_cnt;
    logic [SCORE_W-1:0] score1_nxt;
    logic [SCORE_W-1:0] score2_nxt;

    // Saturating increment candidates, used only in SCORE
    always_comb begin
        score1_nxt = score1_out;
        score2_nxt = score2_out;
        if (score1_out != SCORE_MAX) score1_nxt = score1_out + SCORE_W'(1);
        if (score2_out != SCORE_MAX) score2_nxt = score2_out + SCORE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cd_rst_out       <= 1'b1;
            w_rst_out        <= 1'b1;
            gnt1_out         <= 1'b0;
            gnt2_out         <= 1'b0;
            score1_out       <= '0;
            score2_out       <= '0;
            match_over_out   <= 1'b0;
            match_winner_out <= 2'b00;
            tie_p2           <= 1'b0;
            to_cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state      <= COUNTDOWN;
                        cd_rst_out <= 1'b0;
                        score1_out <= '0;
                        score2_out <= '0;
                    end
                end

                COUNTDOWN: begin
`ifdef ARBITER_MATCH_FOUL_EN
                    // A press before the countdown ends hands the round to the opponent
                    if (req1 && req2) begin
                        state      <= RELEASE;
                        cd_rst_out <= 1'b1;
                    end else if (req1) begin
                        state      <= SHOW;
                        gnt2_out   <= 1'b1;
                        cd_rst_out <= 1'b1;
                        w_rst_out  <= 1'b0;
                    end else if (req2) begin
                        state      <= SHOW;
                        gnt1_out   <= 1'b1;
                        cd_rst_out <= 1'b1;
                        w_rst_out  <= 1'b0;
                    end else if (cd_done_in) begin
                        state  <= ARMED;
                        to_cnt <= '0;
                    end
`else
                    if (cd_done_in) begin
                        state  <= ARMED;
                        to_cnt <= '0;
                    end
`endif
                end

                ARMED: begin
                    if (req1 && req2) begin
                        // Simultaneous press: rotating priority
                        state      <= SHOW;
                        gnt1_out   <= ~tie_p2;
                        gnt2_out   <= tie_p2;
                        tie_p2     <= ~tie_p2;
                        cd_rst_out <= 1'b1;
                        w_rst_out  <= 1'b0;
                    end else if (req1) begin
                        state      <= SHOW;
                        gnt1_out   <= 1'b1;
                        cd_rst_out <= 1'b1;
                        w_rst_out  <= 1'b0;
                    end else if (req2) begin
                        state      <= SHOW;
                        gnt2_out   <= 1'b1;
                        cd_rst_out <= 1'b1;
                        w_rst_out  <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state      <= RELEASE;
                        cd_rst_out <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                SHOW: begin
                    if (w_done_in) begin
                        state     <= SCORE;
                        w_rst_out <= 1'b1;
                    end
                end

                SCORE: begin
                    gnt1_out <= 1'b0;
                    gnt2_out <= 1'b0;
                    state    <= RELEASE;
                    if (gnt1_out) begin
                        score1_out <= score1_nxt;
                        if (score1_nxt == TARGET) begin
                            state            <= MATCH_END;
                            match_over_out   <= 1'b1;
                            match_winner_out <= 2'b01;
                        end
                    end else if (gnt2_out) begin
                        score2_out <= score2_nxt;
                        if (score2_nxt == TARGET) begin
                            state            <= MATCH_END;
                            match_over_out   <= 1'b1;
                            match_winner_out <= 2'b10;
                        end
                    end
                end

                RELEASE: begin
                    // Held buttons must be let go before the next countdown
                    if (!req1 && !req2) begin
                        state      <= COUNTDOWN;
                        cd_rst_out <= 1'b0;
                    end
                end

                MATCH_END: begin
                    if (start_in) begin
                        state            <= COUNTDOWN;
                        cd_rst_out       <= 1'b0;
                        score1_out       <= '0;
                        score2_out       <= '0;
                        match_over_out   <= 1'b0;
                        match_winner_out <= 2'b00;
                    end
                end

                default: begin
                    state      <= IDLE;
                    cd_rst_out <= 1'b1;
                    w_rst_out  <= 1'b1;
                    gnt1_out   <= 1'b0;
                    gnt2_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_match_ctrl.sv
// Directed vector bench for arbiter_match_ctrl; a shortened timeout keeps the void-round cases quick.
module tb_arbiter_match_ctrl;

    localparam int unsigned TO = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_in = 1'b0;
    logic       req1 = 1'b0;
    logic       req2 = 1'b0;
    logic       cd_done_in = 1'b0;
    logic       w_done_in = 1'b0;
    logic       cd_rst_out;
    logic       w_rst_out;
    logic       gnt1_out;
    logic       gnt2_out;
    logic [2:0] score1_out;
    logic [2:0] score2_out;
    logic       match_over_out;
    logic [1:0] match_winner_out;

    int n_vec = 0;
    int n_err = 0;

    arbiter_match_ctrl #(
        .ROUNDS_TO_WIN (3),
        .SCORE_W       (3),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_in        (start_in),
        .req1            (req1),
        .req2            (req2),
        .cd_done_in      (cd_done_in),
        .w_done_in       (w_done_in),
        .cd_rst_out      (cd_rst_out),
        .w_rst_out       (w_rst_out),
        .gnt1_out        (gnt1_out),
        .gnt2_out        (gnt2_out),
        .score1_out      (score1_out),
        .score2_out      (score2_out),
        .match_over_out  (match_over_out),
        .match_winner_out(match_winner_out)
    );

    always #5 clk = ~clk;

    // in = {reset, start, req1, req2, cd_done, w_done}; g = {gnt2, gnt1}
    typedef struct packed {
        logic [5:0] in;
        logic       cdr;
        logic       wr;
        logic [1:0] g;
        logic [2:0] s1;
        logic [2:0] s2;
        logic       mo;
        logic [1:0] mw;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] in, input logic cdr, input logic wr,
                                input logic [1:0] g, input logic [2:0] s1, input logic [2:0] s2,
                                input logic mo, input logic [1:0] mw);
        vec_t v;
        v.in = in; v.cdr = cdr; v.wr = wr; v.g = g;
        v.s1 = s1; v.s2 = s2; v.mo = mo; v.mw = mw;
        return v;
    endfunction

    task automatic run(input string nm, input vec_t v);
        logic [12:0] act;
        logic [12:0] exp;
        {reset, start_in, req1, req2, cd_done_in, w_done_in} = v.in;
        @(posedge clk);
        #1;
        act = {cd_rst_out, w_rst_out, gnt2_out, gnt1_out, score1_out, score2_out,
               match_over_out, match_winner_out};
        exp = {v.cdr, v.wr, v.g, v.s1, v.s2, v.mo, v.mw};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got cdr=%b wr=%b gnt=%b s1=%0d s2=%0d mo=%b mw=%b, expected cdr=%b wr=%b gnt=%b s1=%0d s2=%0d mo=%b mw=%b",
                     nm, cd_rst_out, w_rst_out, {gnt2_out, gnt1_out}, score1_out, score2_out,
                     match_over_out, match_winner_out,
                     v.cdr, v.wr, v.g, v.s1, v.s2, v.mo, v.mw);
        end
    endtask

    initial begin
        vec_t       vq[$];
        logic [2:0] es1;
        logic [2:0] es2;

        // reset, single press by player 1, scored
        vq.push_back(mk(6'b100000, 1, 1, 2'b00, 0, 0, 0, 2'b00));
        vq.push_back(mk(6'b010000, 0, 1, 2'b00, 0, 0, 0, 2'b00));
        vq.push_back(mk(6'b010000, 0, 1, 2'b00, 0, 0, 0, 2'b00));
        vq.push_back(mk(6'b000010, 0, 1, 2'b00, 0, 0, 0, 2'b00));
        vq.push_back(mk(6'b001000, 1, 0, 2'b01, 0, 0, 0, 2'b00));
        vq.push_back(mk(6'b000100, 1, 0, 2'b01, 0, 0, 0, 2'b00));
        vq.push_back(mk(6'b000001, 1, 1, 2'b01, 0, 0, 0, 2'b00));
        vq.push_back(mk(6'b000000, 1, 1, 2'b00, 1, 0, 0, 2'b00));
        vq.push_back(mk(6'b000000, 0, 1, 2'b00, 1, 0, 0, 2'b00));
        // two ties: player 1 then player 2
        vq.push_back(mk(6'b000010, 0, 1, 2'b00, 1, 0, 0, 2'b00));
        vq.push_back(mk(6'b001100, 1, 0, 2'b01, 1, 0, 0, 2'b00));
        vq.push_back(mk(6'b000001, 1, 1, 2'b01, 1, 0, 0, 2'b00));
        vq.push_back(mk(6'b000000, 1, 1, 2'b00, 2, 0, 0, 2'b00));
        vq.push_back(mk(6'b000000, 0, 1, 2'b00, 2, 0, 0, 2'b00));
        vq.push_back(mk(6'b000010, 0, 1, 2'b00, 2, 0, 0, 2'b00));
        vq.push_back(mk(6'b001100, 1, 0, 2'b10, 2, 0, 0, 2'b00));
        vq.push_back(mk(6'b000001, 1, 1, 2'b10, 2, 0, 0, 2'b00));
        vq.push_back(mk(6'b000000, 1, 1, 2'b00, 2, 1, 0, 2'b00));
        vq.push_back(mk(6'b000000, 0, 1, 2'b00, 2, 1, 0, 2'b00));
        // player 2 wins holding req2 through SCORE, RELEASE waits
        vq.push_back(mk(6'b000010, 0, 1, 2'b00, 2, 1, 0, 2'b00));
        vq.push_back(mk(6'b000100, 1, 0, 2'b10, 2, 1, 0, 2'b00));
        vq.push_back(mk(6'b000101, 1, 1, 2'b10, 2, 1, 0, 2'b00));
        vq.push_back(mk(6'b000100, 1, 1, 2'b00, 2, 2, 0, 2'b00));
        vq.push_back(mk(6'b000100, 1, 1, 2'b00, 2, 2, 0, 2'b00));
        vq.push_back(mk(6'b000000, 0, 1, 2'b00, 2, 2, 0, 2'b00));
        // third win for player 2 ends the match; restart clears scores
        vq.push_back(mk(6'b000010, 0, 1, 2'b00, 2, 2, 0, 2'b00));
        vq.push_back(mk(6'b000100, 1, 0, 2'b10, 2, 2, 0, 2'b00));
        vq.push_back(mk(6'b000001, 1, 1, 2'b10, 2, 2, 0, 2'b00));
        vq.push_back(mk(6'b000000, 1, 1, 2'b00, 2, 3, 1, 2'b10));
        vq.push_back(mk(6'b001000, 1, 1, 2'b00, 2, 3, 1, 2'b10));
        vq.push_back(mk(6'b010000, 0, 1, 2'b00, 0, 0, 0, 2'b00));

        for (int i = 0; i < vq.size(); i++) begin
            run($sformatf("vec%0d", i), vq[i]);
        end

        es1 = 3'd0;
        es2 = 3'd0;
`ifdef ARBITER_MATCH_FOUL_EN
        run("foul_gnt2",    mk(6'b001000, 1, 0, 2'b10, es1, es2, 0, 2'b00));
        run("foul_show_wd", mk(6'b000001, 1, 1, 2'b10, es1, es2, 0, 2'b00));
        es2 = 3'd1;
        run("foul_score",   mk(6'b000000, 1, 1, 2'b00, es1, es2, 0, 2'b00));
        run("foul_release", mk(6'b000000, 0, 1, 2'b00, es1, es2, 0, 2'b00));
`else
        run("cd_req_ignored", mk(6'b001000, 0, 1, 2'b00, es1, es2, 0, 2'b00));
        run("cd_req_drop",    mk(6'b000000, 0, 1, 2'b00, es1, es2, 0, 2'b00));
`endif

        // void round after TO idle cycles in ARMED
        run("to_arm", mk(6'b000010, 0, 1, 2'b00, es1, es2, 0, 2'b00));
        for (int k = 1; k < int'(TO); k++) begin
            run($sformatf("to_wait%0d", k), mk(6'b000000, 0, 1, 2'b00, es1, es2, 0, 2'b00));
        end
        run("to_void",    mk(6'b000000, 1, 1, 2'b00, es1, es2, 0, 2'b00));
        run("to_back_cd", mk(6'b000000, 0, 1, 2'b00, es1, es2, 0, 2'b00));

        // press on the last ARMED cycle still wins, then reset during SHOW
        run("edge_arm", mk(6'b000010, 0, 1, 2'b00, es1, es2, 0, 2'b00));
        for (int k = 1; k < int'(TO); k++) begin
            run($sformatf("edge_wait%0d", k), mk(6'b000000, 0, 1, 2'b00, es1, es2, 0, 2'b00));
        end
        run("edge_press",  mk(6'b000100, 1, 0, 2'b10, es1, es2, 0, 2'b00));
        run("rst_in_show", mk(6'b100000, 1, 1, 2'b00, 0, 0, 0, 2'b00));
        run("idle_hold",   mk(6'b000100, 1, 1, 2'b00, 0, 0, 0, 2'b00));
        run("idle_start",  mk(6'b010000, 0, 1, 2'b00, 0, 0, 0, 2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
